// File: rtl/ps2_matrix_mapper.sv
// PS/2 scancode to low-active ROWS x COLS keyboard matrix through a runtime-loadable keymap RAM.
// Define PS2_MATRIX_RELEASE_DELAY_EN to stretch key releases through a timestamped release queue.
module ps2_matrix_mapper #(
    parameter int          ROWS        = 8,
    parameter int          COLS        = 8,
    parameter int          HOLD_CYCLES = 40000,
    parameter int          REL_DEPTH   = 8,
    parameter logic [8:0]  RESET_CODE  = 9'h078,
    localparam int         RW          = $clog2(ROWS),
    localparam int         CW          = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid,
    input  logic [15:0]           key,
    input  logic                  key_status,
    input  logic                  map_we,
    input  logic [8:0]            map_addr,
    input  logic [RW+CW:0]        map_data,
    input  logic [ROWS-1:0]       row_sel_n,
    output logic [COLS-1:0]       col_n,
    output logic [ROWS*COLS-1:0]  km,
    output logic                  resetkey,
    output logic                  busy,
    output logic                  rel_ovf
);
    localparam int MW = 1 + RW + CW;
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);

    if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 || REL_DEPTH < 2 ||
        (REL_DEPTH & (REL_DEPTH - 1)) != 0 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("ps2_matrix_mapper: parameter out of range");
    end

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e         state_q;
    logic [8:0]     clr_cnt_q;
    logic           busy_q;

    logic [MW-1:0]  keymap [512];
    logic [MW-1:0]  rd_q;
    logic           s1_valid_q, s1_status_q, s1_rst_q;
    logic [N-1:0]   km_q, km_d;
    logic           resetkey_q;

    logic           hdr_ok;
    logic [8:0]     code9;
    logic           ent_en, ent_hit;
    logic [RW-1:0]  ent_row;
    logic [CW-1:0]  ent_col;
    logic [IW-1:0]  ent_idx;

    assign hdr_ok = (key[15:8] == 8'h00) || (key[15:8] == 8'hE0);
    assign code9  = {key[15:8] == 8'hE0, key[7:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 9'd1;
            if (clr_cnt_q == 9'd511) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b0;
            end
        end
    end

    // NOTE: the keymap RAM has no reset; the CLEAR sweep initialises it so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            keymap[clr_cnt_q] <= '0;
        end else if (map_we) begin
            keymap[map_addr] <= map_data;
        end
        rd_q <= keymap[code9];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_status_q <= 1'b0;
            s1_rst_q    <= 1'b0;
        end else begin
            s1_valid_q  <= valid && hdr_ok && (state_q == ST_RUN);
            s1_status_q <= key_status;
            s1_rst_q    <= (code9 == RESET_CODE);
        end
    end

    assign {ent_en, ent_row, ent_col} = rd_q;
    assign ent_hit = s1_valid_q && ent_en && (int'(ent_row) < ROWS) && (int'(ent_col) < COLS);
    assign ent_idx = IW'(ent_row) * IW'(COLS) + IW'(ent_col);

`ifdef PS2_MATRIX_RELEASE_DELAY_EN
    localparam int TSW = $clog2(HOLD_CYCLES) + 1;
    localparam int QW  = $clog2(REL_DEPTH);

    logic [IW-1:0]  q_idx [REL_DEPTH];
    logic [TSW-1:0] q_ts  [REL_DEPTH];
    logic [QW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [QW:0]    cnt_q;
    logic [TSW-1:0] ts_q, head_age;
    logic [N-1:0]   pend_q, pend_d;
    logic           rel_ovf_q, rel_ovf_d;
    logic           pop, push;

    // Modular age is exact because no entry can outlive HOLD_CYCLES+REL_DEPTH cycles.
    assign head_age = ts_q - q_ts[rd_ptr_q];
    assign pop      = (cnt_q != '0) && (head_age >= TSW'(HOLD_CYCLES));

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        km_d      = km_q;
        pend_d    = pend_q;
        rel_ovf_d = rel_ovf_q;
        push      = 1'b0;
        if (pop && pend_q[q_idx[rd_ptr_q]]) begin
            km_d[q_idx[rd_ptr_q]]   = 1'b1;
            pend_d[q_idx[rd_ptr_q]] = 1'b0;
        end
        // The stage-1 event is applied last so it overrides a pop on the same key.
        if (ent_hit) begin
            if (s1_status_q) begin
                km_d[ent_idx]   = 1'b0;
                pend_d[ent_idx] = 1'b0;
            end else if (cnt_q != (QW+1)'(REL_DEPTH) || pop) begin
                push            = 1'b1;
                pend_d[ent_idx] = 1'b1;
                km_d[ent_idx]   = km_q[ent_idx];
            end else begin
                km_d[ent_idx]   = 1'b1;
                pend_d[ent_idx] = 1'b0;
                rel_ovf_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q      <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            rel_ovf_q <= 1'b0;
        end else begin
            ts_q      <= ts_q + TSW'(1);
            rd_ptr_q  <= rd_ptr_q + QW'(pop);
            wr_ptr_q  <= wr_ptr_q + QW'(push);
            cnt_q     <= cnt_q + (QW+1)'(push) - (QW+1)'(pop);
            pend_q    <= pend_d;
            rel_ovf_q <= rel_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr_q] <= ent_idx;
            q_ts[wr_ptr_q]  <= ts_q;
        end
    end

    assign rel_ovf = rel_ovf_q;
`else
    always_comb begin
        km_d = km_q;
        if (ent_hit) begin
            km_d[ent_idx] = ~s1_status_q;
        end
    end

    assign rel_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            km_q       <= '1;
            resetkey_q <= 1'b0;
        end else begin
            km_q <= km_d;
            if (s1_valid_q && s1_rst_q) begin
                resetkey_q <= s1_status_q;
            end
        end
    end

    always_comb begin
        logic acc;
        col_n = '1;
        for (int c = 0; c < COLS; c++) begin
            acc = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                acc = acc & (km_q[r*COLS+c] | row_sel_n[r]);
            end
            col_n[c] = acc;
        end
    end

    assign km       = km_q;
    assign resetkey = resetkey_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ps2_matrix_mapper.sv
// Directed self-checking bench for ps2_matrix_mapper (8x8 matrix, HOLD_CYCLES=100, REL_DEPTH=8).
module tb_ps2_matrix_mapper;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid;
    logic [15:0] key;
    logic        key_status;
    logic        map_we;
    logic [8:0]  map_addr;
    logic [6:0]  map_data;
    logic [7:0]  row_sel_n;
    logic [7:0]  col_n;
    logic [63:0] km;
    logic        resetkey;
    logic        busy;
    logic        rel_ovf;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_km;
    logic        exp_ovf;
    int          n;

    ps2_matrix_mapper #(
        .ROWS(8), .COLS(8), .HOLD_CYCLES(100), .REL_DEPTH(8), .RESET_CODE(9'h078)
    ) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .key(key), .key_status(key_status),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data), .row_sel_n(row_sel_n),
        .col_n(col_n), .km(km), .resetkey(resetkey), .busy(busy), .rel_ovf(rel_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] k, input logic s);
        valid = 1'b1; key = k; key_status = s;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic map_write(input logic [8:0] a, input logic [6:0] d);
        map_we = 1'b1; map_addr = a; map_data = d;
        @(negedge clk);
        map_we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; valid = 1'b0; key = '0; key_status = 1'b0;
        map_we = 1'b0; map_addr = '0; map_data = '0; row_sel_n = 8'hFF;
        exp_km = '1;
`ifdef PS2_MATRIX_RELEASE_DELAY_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        #23;
        check("rst_km", km, '1);
        check("rst_resetkey", 64'(resetkey), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ovf", 64'(rel_ovf), 64'd0);

        // Release reset and count clocks of CLEAR while poking events that must be dropped.
        @(negedge clk); reset_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            valid = (n == 5); key = 16'h0078; key_status = 1'b1;
            map_we = (n == 300); map_addr = 9'h005; map_data = {1'b1, 3'd0, 3'd1};
            @(negedge clk); n++;
        end
        valid = 1'b0; map_we = 1'b0;
        check("clear_cycles", 64'(n), 64'd512);
        check("clear_km", km, '1);
        check("clear_resetkey", 64'(resetkey), 64'd0);

        send(16'h0005, 1'b1);
        check("clear_we_dropped", km, exp_km);

        map_write(9'h01C, {1'b1, 3'd1, 3'd2});
        valid = 1'b1; key = 16'h001C; key_status = 1'b1;
        @(negedge clk); valid = 1'b0;
        check("press_lat1", km, '1);
        @(negedge clk);
        exp_km[10] = 1'b0;
        check("press_1c", km, exp_km);
        row_sel_n = 8'hFD; #1 check("col_row1", 64'(col_n), 64'hFB);
        row_sel_n = 8'hFE; #1 check("col_row0", 64'(col_n), 64'hFF);
        row_sel_n = 8'h00; #1 check("col_all", 64'(col_n), 64'hFB);
        row_sel_n = 8'hFF;
        @(negedge clk);

        map_write(9'h175, {1'b1, 3'd5, 3'd7});
        send(16'hE075, 1'b1);
        exp_km[47] = 1'b0;
        check("press_e075", km, exp_km);
        send(16'h0075, 1'b1);
        check("unmapped_0075", km, exp_km);

        map_write(9'h033, {1'b1, 3'd2, 3'd3});
        send(16'hF033, 1'b1);
        check("bad_prefix", km, exp_km);
        map_write(9'h044, {1'b0, 3'd3, 3'd3});
        send(16'h0044, 1'b1);
        check("entry_disabled", km, exp_km);
        send(16'h001C, 1'b1);
        check("dup_press", km, exp_km);

        send(16'h001C, 1'b0);
`ifdef PS2_MATRIX_RELEASE_DELAY_EN
        check("rel_held", km, exp_km);
        repeat (99) @(negedge clk);
        check("rel_hold_end", km, exp_km);
        @(negedge clk);
        exp_km[10] = 1'b1;
        check("rel_applied", km, exp_km);
`else
        exp_km[10] = 1'b1;
        check("rel_direct", km, exp_km);
`endif

        // Nine keys on indices 16..24, pressed then released back to back.
        for (int i = 0; i < 9; i++) begin
            map_write(9'h010 + 9'(i), {1'b1, 3'((16 + i) / 8), 3'((16 + i) % 8)});
        end
        for (int i = 0; i < 9; i++) begin
            valid = 1'b1; key = 16'h0010 + 16'(i); key_status = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        @(negedge clk);
        exp_km[24:16] = '0;
        check("burst_press", km, exp_km);
        for (int i = 0; i < 9; i++) begin
            valid = 1'b1; key = 16'h0010 + 16'(i); key_status = 1'b0;
            @(negedge clk);
        end
        valid = 1'b0;
        @(negedge clk);
`ifdef PS2_MATRIX_RELEASE_DELAY_EN
        exp_km[24] = 1'b1;
`else
        exp_km[24:16] = '1;
`endif
        check("burst_release", km, exp_km);
        check("ovf_set", 64'(rel_ovf), 64'(exp_ovf));
        repeat (110) @(negedge clk);
        exp_km[24:16] = '1;
        check("burst_drained", km, exp_km);
        check("ovf_sticky", 64'(rel_ovf), 64'(exp_ovf));

        send(16'h0078, 1'b1);
        check("resetkey_press", 64'(resetkey), 64'd1);
        check("resetkey_no_map", km, exp_km);
        send(16'h0078, 1'b0);
        check("resetkey_release", 64'(resetkey), 64'd0);
        send(16'h0078, 1'b1);
        send(16'h001C, 1'b1);
        exp_km[10] = 1'b0;
        check("hold_before_rst", km, exp_km);
        check("resetkey_hold", 64'(resetkey), 64'd1);

        #2 reset_n = 1'b0;
        #1;
        check("async_km", km, '1);
        check("async_resetkey", 64'(resetkey), 64'd0);
        check("async_busy", 64'(busy), 64'd1);
        check("async_ovf", 64'(rel_ovf), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
